uart_alu_interface: RTL and testbench
=====================================

// Module: uart_alu_interface
// PURPOSE
//  Sits directly downstream of the UART receiver and upstream of its transmitter.
//  Collects three received bytes (operand A, operand B, opcode), computes an ALU result
//  and hands it to the transmitter with a one-cycle start pulse. It then waits for the
//  transmitter's done before accepting the next frame.
//  Includes an inter-byte timeout counter so that a partial frame does not hang the FSM.
// PARAMETERS
//  NB_DATA         8       data/operand width, equal to the UART data width
//  NB_OP           6       opcode width (the low NB_OP bits of the third byte)
//  TIMEOUT_CYCLES  50000000  max i_clk cycles between bytes of one frame; 0 disables the timeout
// PORTS
//  i_clk       in   1        system clock
//  i_reset     in   1        asynchronous reset, active-low
//  i_rx_done   in   1        one-cycle pulse: i_rx_data holds a new byte
//  i_rx_data   in   NB_DATA  received byte
//  i_tx_done   in   1        one-cycle pulse: transmitter finished the current byte
//  o_tx_start  out  1        one-cycle pulse: start transmitting o_tx_data
//  o_tx_data   out  NB_DATA  result byte; held stable from o_tx_start until i_tx_done
//  o_busy      out  1        high in COMPUTE, SEND and WAIT_TX
//  o_timeout   out  1        one-cycle pulse when a partial frame is discarded
// BEHAVIOUR
//  Reset (i_reset=0, async): state=WAIT_A; A, B, op and result regs=0; timeout cnt=0.
//   All outputs are 0. Reset asserted in any state aborts the frame immediately.
//  Outputs are registered. o_busy is decoded from the state register.
//  FSM states:
//   WAIT_A : on i_rx_done latch A=i_rx_data -> WAIT_B.
//   WAIT_B : on i_rx_done latch B -> WAIT_OP.
//   WAIT_OP: on i_rx_done latch op=i_rx_data[NB_OP-1:0] -> COMPUTE.
//   COMPUTE: exactly 1 cycle; register result -> SEND.
//   SEND   : exactly 1 cycle; o_tx_start=1 and o_tx_data=result -> WAIT_TX.
//   WAIT_TX: on i_tx_done -> WAIT_A. o_tx_data keeps its value until the next SEND.
//  Latency: the o_tx_start pulse comes 2 cycles after the i_rx_done that carried the opcode.
//  Bytes are dropped, with no state change, when i_rx_done arrives in COMPUTE, SEND or
//   WAIT_TX. In WAIT_A/B/OP only i_rx_done pulses are accepted; i_tx_done there is ignored.
//  Opcodes (6-bit), A and B are NB_DATA-bit two's complement:
//   0x20 ADD A+B | 0x22 SUB A-B | 0x24 AND | 0x25 OR | 0x26 XOR | 0x27 NOR ~(A|B)
//   0x03 SRA A>>>B | 0x02 SRL A>>B
//  Arithmetic rules:
//   The result is truncated to NB_DATA bits; there is no carry or overflow flag.
//   The shift amount is the full unsigned B. B>=NB_DATA gives all sign bits (SRA) or 0 (SRL).
//   An undefined opcode gives result=0, and the result is still transmitted.
//  Timeout:
//   The counter runs only in WAIT_B and WAIT_OP. It clears on i_rx_done and on entry to WAIT_A.
//   If TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES-1: go to WAIT_A, pulse
//    o_timeout for 1 cycle, clear the A/B/op regs.
//   If i_rx_done arrives on that same cycle, the byte wins and no timeout occurs.
//  Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.
// TESTING
//  (bench: NB_DATA=8, TIMEOUT_CYCLES=1000)
//  rx 0x05,0x03,0x20 -> one o_tx_start, 2 cycles after 3rd rx_done; o_tx_data=0x08;
//   o_busy high until i_tx_done.
//  rx 0x03,0x05,0x22 -> 0xFE.  rx 0x80,0x02,0x03 -> 0xE0.  rx 0x80,0x02,0x02 -> 0x20.
//   rx 0xF0,0x0F,0x27 -> 0x00.  rx 0x12,0x34,0x3F -> 0x00.
//  rx 0x05 then 1000 idle cycles -> o_timeout pulse, state WAIT_A, no o_tx_start.
//   Next rx 0x01,0x01,0x20 -> 0x02.
//  Extra rx_done (0xAA) during WAIT_TX -> ignored. After i_tx_done, frame 0x02,0x02,0x24
//   -> 0x02.
//  i_reset low mid-frame (after A,B) -> outputs 0 at once. After release, rx 0x07,0x01,0x20
//   -> 0x08.
//  Random A, B and legal opcodes, 500 frames -> o_tx_data matches the reference model every
//   frame; exactly one o_tx_start per frame.

Source files
------------

// File: rtl/uart_alu_interface.sv
// UART-to-ALU bridge: gathers operand A, operand B and an opcode from the UART receiver,
// computes the result and hands it to the transmitter, then waits for the transmitter's done.
// A partial frame is dropped if the gap between its bytes grows too long.
module uart_alu_interface #(
   parameter int unsigned NB_DATA        = 8,
   parameter int unsigned NB_OP          = 6,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_timeout
);

   // A zero TIMEOUT_CYCLES disables the timeout; the counter keeps a 1-bit minimum width
   localparam bit          TimeoutEn = (TIMEOUT_CYCLES > 0);
   localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [NB_OP-1:0] OpAdd = NB_OP'(6'h20);
   localparam logic [NB_OP-1:0] OpSub = NB_OP'(6'h22);
   localparam logic [NB_OP-1:0] OpAnd = NB_OP'(6'h24);
   localparam logic [NB_OP-1:0] OpOr  = NB_OP'(6'h25);
   localparam logic [NB_OP-1:0] OpXor = NB_OP'(6'h26);
   localparam logic [NB_OP-1:0] OpNor = NB_OP'(6'h27);
   localparam logic [NB_OP-1:0] OpSra = NB_OP'(6'h03);
   localparam logic [NB_OP-1:0] OpSrl = NB_OP'(6'h02);

   typedef enum logic [2:0] {
      StWaitA,
      StWaitB,
      StWaitOp,
      StCompute,
      StSend,
      StWaitTx
   } state_e;

   state_e             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] result_q, result_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               tx_start_q, tx_start_d;
   logic               timeout_q, timeout_d;
   logic [NB_DATA-1:0] alu_result;

   // ALU: result truncated to NB_DATA; shifts use the full unsigned B, so large amounts
   // fill with sign bits (SRA) or zeros (SRL) by the language's shift semantics
   always_comb begin
      alu_result = '0;
      case (op_q)
         OpAdd:   alu_result = a_q + b_q;
         OpSub:   alu_result = a_q - b_q;
         OpAnd:   alu_result = a_q & b_q;
         OpOr:    alu_result = a_q | b_q;
         OpXor:   alu_result = a_q ^ b_q;
         OpNor:   alu_result = ~(a_q | b_q);
         OpSra:   alu_result = $signed(a_q) >>> b_q;
         OpSrl:   alu_result = a_q >> b_q;
         default: alu_result = '0;
      endcase
   end

   // Next-state logic: byte capture, inter-byte timeout, compute and transmit handshake
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      tx_start_d = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         StWaitA: begin
            cnt_d = '0;
            if (i_rx_done) begin
               a_d     = i_rx_data;
               state_d = StWaitB;
            end
         end
         StWaitB, StWaitOp: begin
            if (i_rx_done) begin
               // A byte arriving on the expiry cycle wins over the timeout
               cnt_d = '0;
               if (state_q == StWaitB) begin
                  b_d     = i_rx_data;
                  state_d = StWaitOp;
               end else begin
                  op_d    = i_rx_data[NB_OP-1:0];
                  state_d = StCompute;
               end
            end else if (TimeoutEn && (cnt_q == CntMax)) begin
               state_d   = StWaitA;
               timeout_d = 1'b1;
               a_d       = '0;
               b_d       = '0;
               op_d      = '0;
               cnt_d     = '0;
            end else if (cnt_q != {CntW{1'b1}}) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StCompute: begin
            result_d   = alu_result;
            tx_start_d = 1'b1;
            state_d    = StSend;
         end
         StSend: begin
            state_d = StWaitTx;
         end
         StWaitTx: begin
            if (i_tx_done) begin
               state_d = StWaitA;
            end
         end
         default: state_d = StWaitA;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= StWaitA;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         tx_start_q <= tx_start_d;
         timeout_q  <= timeout_d;
      end
   end

   // result_q only changes on leaving COMPUTE, so it is stable from SEND to the next frame
   assign o_tx_start = tx_start_q;
   assign o_tx_data  = result_q;
   assign o_timeout  = timeout_q;
   assign o_busy     = (state_q == StCompute) || (state_q == StSend) || (state_q == StWaitTx);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed frames, timeout, reset abort and
// randomized frames against an arithmetic reference model.
module tb_uart_alu_interface;

   localparam int unsigned NB_DATA = 8;
   localparam int unsigned NB_OP   = 6;
   localparam int unsigned TOUT    = 1000;

   logic               clk;
   logic               rst_n;
   logic               rx_done;
   logic [NB_DATA-1:0] rx_data;
   logic               tx_done;
   logic               tx_start;
   logic [NB_DATA-1:0] tx_data;
   logic               busy;
   logic               timeout;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   int timeout_cnt = 0;

   uart_alu_interface #(
      .NB_DATA        (NB_DATA),
      .NB_OP          (NB_OP),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_rx_done  (rx_done),
      .i_rx_data  (rx_data),
      .i_tx_done  (tx_done),
      .o_tx_start (tx_start),
      .o_tx_data  (tx_data),
      .o_busy     (busy),
      .o_timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count output pulses as seen at each clock edge
   always @(posedge clk) begin
      if (tx_start) start_cnt <= start_cnt + 1;
      if (timeout)  timeout_cnt <= timeout_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference ALU from the arithmetic rules, in plain integers
   function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
      int r, sa, p, q;
      sa = (a >= 128) ? a - 256 : a;
      case (op)
         32: r = (a + b) % 256;
         34: r = (a - b + 256) % 256;
         36: r = a & b;
         37: r = a | b;
         38: r = a ^ b;
         39: r = 255 - (a | b);
         3: begin
            if (b >= 8) r = (sa < 0) ? 255 : 0;
            else begin
               p = 1 << b;
               q = sa / p;
               if (sa < 0 && (sa % p) != 0) q = q - 1;  // floor division
               r = q & 255;
            end
         end
         2: r = (b >= 8) ? 0 : a / (1 << b);
         default: r = 0;
      endcase
      return 8'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      tick();
      rx_done = 1'b0;
      rx_data = $urandom_range(0, 255);
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input bit extra, input int gmax);
      logic [7:0] exp;
      int         starts0;
      int         n;
      exp     = ref_alu(int'(a), int'(b), int'(opb[5:0]));
      starts0 = start_cnt;
      send_byte(a);
      idle($urandom_range(0, gmax));
      send_byte(b);
      idle($urandom_range(0, gmax));
      send_byte(opb);
      // COMPUTE: no start yet, already busy
      check("start_in_compute", tx_start, 1'b0);
      check("busy_compute", busy, 1'b1);
      tick();
      // SEND: start pulse 2 cycles after the opcode byte
      check("tx_start", tx_start, 1'b1);
      check("tx_data", tx_data, exp);
      tick();
      if (extra) send_byte(8'hAA);
      n = $urandom_range(0, 3);
      for (int i = 0; i <= n; i++) begin
         check("start_pulse_len", tx_start, 1'b0);
         check("busy_wait_tx", busy, 1'b1);
         check("tx_data_hold", tx_data, exp);
         if (i < n) tick();
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("busy_after_done", busy, 1'b0);
      check("tx_data_after_done", tx_data, exp);
      check("one_start_per_frame", start_cnt, starts0 + 1);
   endtask

   int ops[8] = '{32, 34, 36, 37, 38, 39, 3, 2};

   initial begin
      int seen;
      int starts0;
      int tout0;
      logic [7:0] ra, rb, rop;
      rst_n   = 1'b0;
      rx_done = 1'b0;
      rx_data = '0;
      tx_done = 1'b0;
      idle(3);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      rst_n = 1'b1;
      tick();

      // Directed frames
      run_frame(8'h05, 8'h03, 8'h20, 1'b0, 0);
      run_frame(8'h03, 8'h05, 8'h22, 1'b0, 0);
      run_frame(8'h80, 8'h02, 8'h03, 1'b0, 0);
      run_frame(8'h80, 8'h02, 8'h02, 1'b0, 0);
      run_frame(8'hF0, 8'h0F, 8'h27, 1'b0, 0);
      run_frame(8'h12, 8'h34, 8'h3F, 1'b0, 0);
      run_frame(8'h80, 8'h09, 8'h03, 1'b0, 2);
      run_frame(8'hFF, 8'h20, 8'h02, 1'b0, 2);

      // Partial frame times out after TOUT idle cycles following the last byte
      starts0 = start_cnt;
      tout0   = timeout_cnt;
      send_byte(8'h05);
      seen = 0;
      for (int i = 1; i <= TOUT + 100; i++) begin
         tick();
         if (timeout) begin
            seen = i;
            break;
         end
      end
      check("timeout_cycle", seen, TOUT);
      check("busy_at_timeout", busy, 1'b0);
      tick();
      check("timeout_pulse_len", timeout, 1'b0);
      check("timeout_pulse_count", timeout_cnt, tout0 + 1);
      check("no_start_on_timeout", start_cnt, starts0);
      run_frame(8'h01, 8'h01, 8'h20, 1'b0, 0);

      // Stray byte while waiting for the transmitter is dropped
      run_frame(8'h09, 8'h04, 8'h20, 1'b1, 0);
      run_frame(8'h02, 8'h02, 8'h24, 1'b0, 0);

      // Reset in the middle of a frame clears outputs immediately
      send_byte(8'h33);
      send_byte(8'h44);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_data", tx_data, 8'h00);
      check("midrst_busy", busy, 1'b0);
      check("midrst_tx_start", tx_start, 1'b0);
      check("midrst_timeout", timeout, 1'b0);
      idle(2);
      rst_n = 1'b1;
      tick();
      run_frame(8'h07, 8'h01, 8'h20, 1'b0, 0);

      // Randomized frames
      for (int f = 0; f < 500; f++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 9));
         rop = 8'(ops[$urandom_range(0, 7)]) | {$urandom_range(0, 3), 6'b0};
         run_frame(ra, rb, rop, ($urandom_range(0, 7) == 0), 3);
         idle($urandom_range(0, 2));
      end
      check("no_spurious_timeout", timeout_cnt, tout0 + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
